// File: rtl/token_stream_bridge_pkg.sv
// Shared types and constants for the token stream bridge.
package token_bridge_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

endpackage

// File: rtl/token_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible whenever non-empty (zero when empty).
module token_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             push_ok, pop_ok;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;
    assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wr_d    = wr_q + {{AW{1'b0}}, push_ok};
        rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/token_stream_bridge.sv
// GPIO <-> inference token bridge: execute-edge start, show-ahead token FIFO, toggle pop, status.
// Optional stall watchdog enabled with TOKEN_BRIDGE_TIMEOUT_EN.
module token_stream_bridge
    import token_bridge_pkg::*;
#(
    parameter int CHAR_W      = 8,
    parameter int COUNT_W     = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 16777216
) (
    input  logic                              clk,
    input  logic                              reset_rtl_0,
    input  logic                              gpio_execute_i,
    input  logic                              gpio_pop_toggle_i,
    output logic                              start_o,
    input  logic                              tok_valid_i,
    input  logic [CHAR_W-1:0]                 tok_data_i,
    input  logic                              tok_last_i,
    output logic                              tok_ready_o,
    output logic [CHAR_W-1:0]                 gpio_head_ascii_o,
    output logic                              gpio_head_valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   gpio_fifo_level_o,
    output logic [COUNT_W-1:0]                gpio_generate_count_o,
    output logic [2:0]                        gpio_status_o,
    output logic                              abort_o
);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_e             state_q, state_d;
    logic               exec_q, pop_q;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               exec_rise, pop_req, start, accept, abort, timeout_bit;
    logic               fifo_full, fifo_empty;
    logic [LVL_W-1:0]   fifo_level, level_after;

`ifdef TOKEN_BRIDGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_bit = timeout_q;
`else
    assign timeout_bit = 1'b0;
`endif

    assign exec_rise   = gpio_execute_i && !exec_q;
    assign pop_req     = gpio_pop_toggle_i ^ pop_q;
    assign tok_ready_o = (state_q == RUN) && !fifo_full;
    assign accept      = tok_valid_i && tok_ready_o;
    assign level_after = fifo_level + LVL_W'(accept) - LVL_W'(pop_req && !fifo_empty);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        start   = 1'b0;
        abort   = 1'b0;
`ifdef TOKEN_BRIDGE_TIMEOUT_EN
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (exec_rise) begin
                    start   = 1'b1;
                    state_d = RUN;
                    count_d = '0;
`ifdef TOKEN_BRIDGE_TIMEOUT_EN
                    tmr_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    if (count_q != '1) count_d = count_q + 1'b1;
`ifdef TOKEN_BRIDGE_TIMEOUT_EN
                    tmr_d = '0;
`endif
                    if (tok_last_i) state_d = (level_after != '0) ? DRAIN : DONE;
                end
`ifdef TOKEN_BRIDGE_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    abort     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = (level_after != '0) ? DRAIN : DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (level_after == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Execute shadow resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q <= IDLE;
            exec_q  <= 1'b1;
            pop_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            exec_q  <= gpio_execute_i;
            pop_q   <= gpio_pop_toggle_i;
            count_q <= count_d;
        end
    end

    token_fifo #(.WIDTH(CHAR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset_rtl_0),
        .flush (start),
        .push  (accept),
        .pop   (pop_req),
        .din   (tok_data_i),
        .dout  (gpio_head_ascii_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        gpio_status_o               = '0;
        gpio_status_o[STAT_BUSY]    = (state_q == RUN) || (state_q == DRAIN);
        gpio_status_o[STAT_DONE]    = (state_q == DONE);
        gpio_status_o[STAT_TIMEOUT] = timeout_bit;
    end

    assign start_o               = start;
    assign abort_o               = abort;
    assign gpio_head_valid_o     = !fifo_empty;
    assign gpio_fifo_level_o     = fifo_level;
    assign gpio_generate_count_o = count_q;

endmodule

// File: tb/tb_token_stream_bridge.sv
// Randomised bench for token_stream_bridge against a queue-based reference model.
module tb_token_stream_bridge;
    localparam int CHAR_W  = 8;
    localparam int COUNT_W = 4;
    localparam int DEPTH   = 16;
    localparam int TMO     = 100;
    localparam int LVL_W   = $clog2(DEPTH+1);
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic reset_rtl_0, gpio_execute_i, gpio_pop_toggle_i;
    logic start_o, tok_valid_i, tok_last_i, tok_ready_o, gpio_head_valid_o, abort_o;
    logic [CHAR_W-1:0]  tok_data_i, gpio_head_ascii_o;
    logic [LVL_W-1:0]   gpio_fifo_level_o;
    logic [COUNT_W-1:0] gpio_generate_count_o;
    logic [2:0]         gpio_status_o;

    always #5 clk = ~clk;

    token_stream_bridge #(.CHAR_W(CHAR_W), .COUNT_W(COUNT_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_rtl_0(reset_rtl_0), .gpio_execute_i(gpio_execute_i),
        .gpio_pop_toggle_i(gpio_pop_toggle_i), .start_o(start_o), .tok_valid_i(tok_valid_i),
        .tok_data_i(tok_data_i), .tok_last_i(tok_last_i), .tok_ready_o(tok_ready_o),
        .gpio_head_ascii_o(gpio_head_ascii_o), .gpio_head_valid_o(gpio_head_valid_o),
        .gpio_fifo_level_o(gpio_fifo_level_o), .gpio_generate_count_o(gpio_generate_count_o),
        .gpio_status_o(gpio_status_o), .abort_o(abort_o)
    );

    int n_chk = 0, n_pass = 0;

    // reference model
    logic [CHAR_W-1:0] q[$];
    int m_st, m_cnt, m_tmr;
    bit m_exec_prev, m_pop_prev, m_timeout;
    int n_abort = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_st = S_IDLE; m_cnt = 0; m_tmr = 0;
        m_exec_prev = 1'b1; m_pop_prev = 1'b0; m_timeout = 1'b0;
    endtask

    task automatic chk_state(input string pfx);
        chk({pfx, "_level"}, 32'(gpio_fifo_level_o), q.size());
        chk({pfx, "_hvalid"}, 32'(gpio_head_valid_o), 32'(q.size() != 0));
        chk({pfx, "_head"}, 32'(gpio_head_ascii_o), (q.size() != 0) ? 32'(q[0]) : 0);
        chk({pfx, "_count"}, 32'(gpio_generate_count_o), m_cnt);
        chk({pfx, "_status"}, 32'(gpio_status_o),
            {29'd0, m_timeout, m_st == S_DONE, (m_st == S_RUN) || (m_st == S_DRAIN)});
    endtask

    // Drive one cycle from a negedge, check pre-edge outputs, advance the model at the posedge.
    task automatic step(input bit v, input logic [CHAR_W-1:0] d, input bit l);
        bit rise, st_e, rdy, acc, ab, pr;
        tok_valid_i = v; tok_data_i = d; tok_last_i = l;
        #1;
        rise = gpio_execute_i && !m_exec_prev;
        st_e = rise && (m_st == S_IDLE || m_st == S_DONE);
        rdy  = (m_st == S_RUN) && (q.size() < DEPTH);
        acc  = rdy && v;
        ab   = 1'b0;
`ifdef TOKEN_BRIDGE_TIMEOUT_EN
        ab = (m_st == S_RUN) && !acc && (m_tmr == TMO - 1);
`endif
        chk("start", 32'(start_o), 32'(st_e));
        chk("ready", 32'(tok_ready_o), 32'(rdy));
        chk("abort", 32'(abort_o), 32'(ab));
        chk_state("cyc");
        if (abort_o) n_abort++;
        @(posedge clk);
        pr = gpio_pop_toggle_i != m_pop_prev;
        m_pop_prev  = gpio_pop_toggle_i;
        m_exec_prev = gpio_execute_i;
        if (st_e) begin
            q.delete(); m_cnt = 0; m_tmr = 0; m_timeout = 1'b0; m_st = S_RUN;
        end else begin
            if (pr && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(d);
                if (m_cnt < (1 << COUNT_W) - 1) m_cnt++;
                m_tmr = 0;
            end
            if (m_st == S_RUN) begin
                if (acc && l) m_st = (q.size() != 0) ? S_DRAIN : S_DONE;
                else if (ab) begin
                    m_timeout = 1'b1;
                    m_st = (q.size() != 0) ? S_DRAIN : S_DONE;
                end else if (!acc) m_tmr++;
            end else if (m_st == S_DRAIN && q.size() == 0) m_st = S_DONE;
        end
        @(negedge clk);
    endtask

    task automatic tog_step(input bit v, input logic [CHAR_W-1:0] d, input bit l);
        gpio_pop_toggle_i = ~gpio_pop_toggle_i;
        step(v, d, l);
    endtask

    task automatic launch();
        gpio_execute_i = 1'b0; step(0, 0, 0);
        gpio_execute_i = 1'b1; step(0, 0, 0);
    endtask

    task automatic drain_all();
        int guard = 0;
        while (q.size() != 0 && guard < 40) begin tog_step(0, 0, 0); guard++; end
        chk("drain_bound", guard, (guard < 40) ? guard : 0);
    endtask

    initial begin
        model_reset();
        reset_rtl_0 = 1'b0; gpio_execute_i = 1'b1; gpio_pop_toggle_i = 1'b0;
        tok_valid_i = 1'b0; tok_data_i = '0; tok_last_i = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_start", 32'(start_o), 0);
        chk("rst_ready", 32'(tok_ready_o), 0);
        chk_state("rst");
        reset_rtl_0 = 1'b1;

        // execute held high through reset must not start a run
        repeat (3) step(0, 0, 0);

        // run and drain "Hi!" with a re-execute ignored mid-run
        launch();
        step(1, 8'h48, 0);
        gpio_execute_i = 1'b0; step(0, 0, 0);
        gpio_execute_i = 1'b1; step(0, 0, 0);
        chk("reexec_count", 32'(gpio_generate_count_o), 1);
        step(1, 8'h69, 0);
        step(1, 8'h21, 1);
        chk("hi_count", 32'(gpio_generate_count_o), 3);
        chk("hi_level", 32'(gpio_fifo_level_o), 3);
        chk("hi_head", 32'(gpio_head_ascii_o), 32'h48);
        chk("hi_status", 32'(gpio_status_o), 3'b001);
        tog_step(0, 0, 0); chk("pop1_head", 32'(gpio_head_ascii_o), 32'h69);
        tog_step(0, 0, 0); chk("pop2_head", 32'(gpio_head_ascii_o), 32'h21);
        tog_step(0, 0, 0); chk("pop3_valid", 32'(gpio_head_valid_o), 0);
        chk("hi_done", 32'(gpio_status_o), 3'b010);

        // full FIFO, pop at full, simultaneous push/pop
        launch();
        for (int i = 0; i < DEPTH; i++) step(1, CHAR_W'($urandom), 0);
        step(1, 8'hEE, 0);
        chk("full_ready", 32'(tok_ready_o), 0);
        chk("full_level", 32'(gpio_fifo_level_o), DEPTH);
        tog_step(1, 8'hEF, 0);
        #1 chk("refill_ready", 32'(tok_ready_o), 1);
        tog_step(1, 8'hA5, 0);
        chk("pushpop_level", 32'(gpio_fifo_level_o), DEPTH - 1);
        step(1, 8'h5A, 0);
        chk("refull_level", 32'(gpio_fifo_level_o), DEPTH);
        tog_step(0, 0, 0);
        tog_step(1, 8'h0A, 1);
        drain_all();
        step(0, 0, 0);

        // count saturation with continuous pops
        launch();
        for (int i = 0; i < 20; i++) tog_step(1, CHAR_W'(8'h30 + i), i == 19);
        chk("sat_count", 32'(gpio_generate_count_o), (1 << COUNT_W) - 1);
        drain_all();
        step(0, 0, 0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 11) == 0) gpio_execute_i = ~gpio_execute_i;
            if ($urandom_range(0, 2) == 0) gpio_pop_toggle_i = ~gpio_pop_toggle_i;
            step($urandom_range(0, 2) != 0, CHAR_W'($urandom), $urandom_range(0, 15) == 0);
        end

        // asynchronous reset mid-run, no clock edge
        launch();
        for (int i = 0; i < 5; i++) step(1, CHAR_W'(8'h61 + i), 0);
        chk("pre_rst_level", 32'(gpio_fifo_level_o), 5);
        #2 reset_rtl_0 = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", 32'(tok_ready_o), 0);
        chk("arst_start", 32'(start_o), 0);
        chk_state("arst");
        @(negedge clk);
        reset_rtl_0 = 1'b1;
        gpio_pop_toggle_i = 1'b0;
        step(0, 0, 0);
        chk("post_rst_status", 32'(gpio_status_o), 0);

`ifdef TOKEN_BRIDGE_TIMEOUT_EN
        // watchdog: one token then silence
        launch();
        n_abort = 0;
        step(1, 8'h41, 0);
        repeat (TMO + 5) step(0, 0, 0);
        chk("tmo_aborts", n_abort, 1);
        chk("tmo_status", 32'(gpio_status_o), 3'b101);
        drain_all();
        step(0, 0, 0);
        launch();
        chk("tmo_cleared", 32'(gpio_status_o[2]), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got stuck expected finish");
        $fatal(1);
    end
endmodule
